// File: rtl/bcd_to_bin_seq.sv
// Sequential 4-digit packed-BCD to 16-bit binary converter (reverse double-dabble,
// one shift/adjust iteration per clock) with start/busy/done handshake and digit check.
//
// state | meaning
// IDLE  | waiting for start_i; malformed operands are flagged here without converting
// CONV  | 16 shift-right / subtract-3 iterations on the working register
module bcd_to_bin_seq (
   input  logic        clk_i,
   input  logic        rst_ni,
   input  logic        start_i,
   input  logic [15:0] bcd_i,
   output logic        busy_o,
   output logic        done_o,
   output logic        err_o,
   output logic [15:0] bin_o
);

   typedef enum logic {IDLE, CONV} state_t;

   state_t      state_q, state_d;
   logic [31:0] w_q, w_d;
   logic [3:0]  cnt_q, cnt_d;
   logic        busy_q, busy_d;
   logic        done_q, done_d;
   logic        err_q, err_d;
   logic [15:0] bin_q, bin_d;

   logic [31:0] w_shift;
   logic [31:0] w_adj;
   logic        bcd_bad;

   // One iteration: logical shift right, then each BCD nibble >= 8 loses 3 (no inter-nibble carry).
   always_comb begin
      w_shift = w_q >> 1;
      w_adj   = w_shift;
      for (int i = 4; i < 8; i++) begin
         if (w_shift[4*i +: 4] >= 4'd8) begin
            w_adj[4*i +: 4] = w_shift[4*i +: 4] - 4'd3;
         end
      end
   end

   always_comb begin
      bcd_bad = 1'b0;
      for (int i = 0; i < 4; i++) begin
         if (bcd_i[4*i +: 4] > 4'd9) begin
            bcd_bad = 1'b1;
         end
      end
   end

   always_comb begin
      state_d = state_q;
      w_d     = w_q;
      cnt_d   = cnt_q;
      busy_d  = busy_q;
      done_d  = 1'b0;
      err_d   = err_q;
      bin_d   = bin_q;
      case (state_q)
         IDLE: begin
            if (start_i) begin
               if (bcd_bad) begin
                  err_d  = 1'b1;
                  bin_d  = 16'h0;
                  done_d = 1'b1;
               end else begin
                  w_d     = {bcd_i, 16'h0};
                  err_d   = 1'b0;
                  cnt_d   = 4'd0;
                  busy_d  = 1'b1;
                  state_d = CONV;
               end
            end
         end
         CONV: begin
            w_d   = w_adj;
            cnt_d = cnt_q + 4'd1;
            if (cnt_q == 4'd15) begin
               bin_d   = w_adj[15:0];
               done_d  = 1'b1;
               busy_d  = 1'b0;
               state_d = IDLE;
            end
         end
         default: begin
            state_d = IDLE;
            busy_d  = 1'b0;
         end
      endcase
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q <= IDLE;
         w_q     <= 32'h0;
         cnt_q   <= 4'd0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         err_q   <= 1'b0;
         bin_q   <= 16'h0;
      end else begin
         state_q <= state_d;
         w_q     <= w_d;
         cnt_q   <= cnt_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
         err_q   <= err_d;
         bin_q   <= bin_d;
      end
   end

   assign busy_o = busy_q;
   assign done_o = done_q;
   assign err_o  = err_q;
   assign bin_o  = bin_q;

endmodule
